// File: rtl/psum_out_mem_ctrl.sv
// psum output buffer: core write/read port, independent host read port,
// and a clear engine that zeroes the buffer between layers.

// Fixed-latency read pipeline; the last stage holds its data while idle.
module psum_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DELAY  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  v_in,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic                  v_out,
    output logic [DATA_WIDTH-1:0] d_out
);
    logic [MEM_DELAY-1:0]  vld_pipe;
    logic [DATA_WIDTH-1:0] dat_pipe [MEM_DELAY];

    // Shift valid every cycle; the output stage only loads on a real response.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 0; k < MEM_DELAY; k++) dat_pipe[k] <= '0;
        end else begin
            vld_pipe[0] <= v_in;
            if (MEM_DELAY > 1 || v_in) dat_pipe[0] <= d_in;
            for (int k = 1; k < MEM_DELAY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (k < MEM_DELAY - 1 || vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    assign v_out = vld_pipe[MEM_DELAY-1];
    assign d_out = dat_pipe[MEM_DELAY-1];
endmodule

module psum_out_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int MEM_DELAY  = 1,
    parameter int REG_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] memctrl0_wadd,
    input  logic                  memctrl0_wren,
    input  logic [DATA_WIDTH-1:0] memctrl0_idat,
    input  logic [ADDR_WIDTH-1:0] memctrl0_radd,
    input  logic                  memctrl0_rden,
    output logic [DATA_WIDTH-1:0] memctrl0_odat,
    output logic                  memctrl0_ovld,
    input  logic [ADDR_WIDTH-1:0] host_radd,
    input  logic                  host_rden,
    output logic [DATA_WIDTH-1:0] host_odat,
    output logic                  host_ovld,
    input  logic                  i_clear,
    output logic                  o_clear_busy,
    output logic [1:0]            o_err,
    output logic [REG_WIDTH-1:0]  o_wr_cnt
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, CLEAR} state_t;
    state_t                state, state_nx;
    logic [DEPTH_LOG2-1:0] clr_idx, clr_idx_nx;
    logic                  clr_start;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  clearing;
    logic                  wr_oor, rd_oor, h_oor, core_wr_ok;
    logic                  we;
    logic [DEPTH_LOG2-1:0] widx, ridx, hidx;
    logic [DATA_WIDTH-1:0] wdat;
    logic [1:0]                 rd_v;
    logic [1:0][DATA_WIDTH-1:0] rd_d;
    logic [1:0]                 out_v;
    logic [1:0][DATA_WIDTH-1:0] out_d;

    assign clearing   = (state == CLEAR);
    assign wr_oor     = |memctrl0_wadd[ADDR_WIDTH-1:DEPTH_LOG2];
    assign rd_oor     = |memctrl0_radd[ADDR_WIDTH-1:DEPTH_LOG2];
    assign h_oor      = |host_radd[ADDR_WIDTH-1:DEPTH_LOG2];
    assign core_wr_ok = memctrl0_wren & ~wr_oor & ~clearing;
    assign ridx       = memctrl0_radd[DEPTH_LOG2-1:0];
    assign hidx       = host_radd[DEPTH_LOG2-1:0];

    // Single write port shared by the clear engine and core writes.
    assign we   = ~rst & (clearing | core_wr_ok);
    assign widx = clearing ? clr_idx : memctrl0_wadd[DEPTH_LOG2-1:0];
    assign wdat = clearing ? '0 : memctrl0_idat;

    // Read data as of end of the issue cycle: forward the same-cycle write.
    always_comb begin
        rd_v    = {host_rden, memctrl0_rden};
        rd_d[0] = (we && widx == ridx) ? wdat : mem[ridx];
        rd_d[1] = (we && widx == hidx) ? wdat : mem[hidx];
        if (clearing || rd_oor) rd_d[0] = '0;
        if (h_oor)              rd_d[1] = '0;
    end

    // Buffer storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdat;
    end

    // Port 0 = core, port 1 = host.
    for (genvar p = 0; p < 2; p++) begin : g_port
        psum_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .MEM_DELAY(MEM_DELAY)) u_pipe (
            .clk   (clk),
            .rst   (rst),
            .v_in  (rd_v[p]),
            .d_in  (rd_d[p]),
            .v_out (out_v[p]),
            .d_out (out_d[p])
        );
    end

    assign memctrl0_ovld = out_v[0];
    assign memctrl0_odat = out_d[0];
    assign host_ovld     = out_v[1];
    assign host_odat     = out_d[1];

    // Clear FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= clr_idx_nx;
        end
    end

    // Clear FSM next state: sweep every index once, then return to idle.
    always_comb begin
        state_nx   = state;
        clr_idx_nx = clr_idx;
        clr_start  = 1'b0;
        case (state)
            IDLE: begin
                if (i_clear) begin
                    state_nx   = CLEAR;
                    clr_idx_nx = '0;
                    clr_start  = 1'b1;
                end
            end
            CLEAR: begin
                clr_idx_nx = clr_idx + 1'b1;
                if (&clr_idx) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign o_clear_busy = clearing;

    // Sticky errors and saturating write count; both restart on clear entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err    <= '0;
            o_wr_cnt <= '0;
        end else if (clr_start) begin
            o_err    <= '0;
            o_wr_cnt <= '0;
        end else begin
            if ((memctrl0_wren & wr_oor) | (memctrl0_rden & rd_oor) | (host_rden & h_oor))
                o_err[0] <= 1'b1;
            if (clearing & (memctrl0_wren | memctrl0_rden))
                o_err[1] <= 1'b1;
            if (core_wr_ok && !(&o_wr_cnt))
                o_wr_cnt <= o_wr_cnt + 1'b1;
        end
    end
endmodule
